piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer. Next generation of the team's fixed 4-bit shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per shift_en strobe, MSB- or LSB-first.
- Provides busy, bit-valid and end-of-word indications, and supports gapless back-to-back words.
- Sits between a word producer (FIFO/controller) and a bit-serial link clocked by an external baud or bit-rate tick.

Parameters:
- WIDTH, 8, word width in bits (2..64).
- LSB_FIRST, 0, 0 = MSB transmitted first; 1 = LSB transmitted first.
- IDLE_LEVEL, 1'b0, level driven on serial_out when no word is in flight.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  producer has a word on parallel_in.
- load_ready  output  1  serializer can accept a word this cycle.
- parallel_in  input  WIDTH  word to serialize; sampled only on handshake.
- shift_en  input  1  bit-rate strobe; advances to next bit when high.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a data bit.
- busy  output  1  word in flight (SHIFT state).
- done  output  1  one-cycle pulse after final bit of a word retires.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset values:
  - state = IDLE; shift_reg = 0; bit_cnt = 0; done = 0.
  - Hence serial_out = IDLE_LEVEL, serial_valid = 0, busy = 0.
  - load_ready = 0 while rst is high.
- rst asserted mid-word aborts the word immediately. No done pulse; the partial word is discarded.
- State machine:
  - IDLE -> SHIFT on accept (load_valid && load_ready).
  - SHIFT -> IDLE on shift_en with bit_cnt == WIDTH-1 and no simultaneous accept.
  - SHIFT -> SHIFT on that same final shift_en when an accept also occurs (back-to-back).
- load_ready:
  - 1 in IDLE.
  - In SHIFT: 1 only when shift_en && bit_cnt == WIDTH-1 (combinational from shift_en and state).
  - 0 otherwise, including every other SHIFT cycle.
- Accept: shift_reg <= parallel_in and bit_cnt <= 0. parallel_in is ignored in all other cycles.
- Latency: first bit appears on serial_out, with serial_valid = 1, in the cycle after the accept edge. It does not wait for shift_en.
- Bit output (combinational from registered state):
  - serial_out = shift_reg[WIDTH-1] when LSB_FIRST = 0, or shift_reg[0] when LSB_FIRST = 1, while in SHIFT.
  - serial_out = IDLE_LEVEL in IDLE.
  - serial_valid = busy = (state == SHIFT).
- Shift: in SHIFT with shift_en high and bit_cnt < WIDTH-1:
  - shift_reg shifts toward the output end, zero-filling the vacated end.
  - bit_cnt increments.
  - With shift_en low, the current bit is held indefinitely.
- Each bit is therefore valid from its presentation until (and including) the cycle its shift_en is sampled. Exactly WIDTH shift_en strobes retire one word.
- done: registered. High for exactly one cycle following the edge on which the final bit retired; this holds in both the IDLE-return and back-to-back cases.
- shift_en in IDLE has no effect.
- load_valid with load_ready = 0 has no effect. The producer must hold the word; no data is lost or latched.
- bit_cnt width is clog2(WIDTH) bits and never exceeds WIDTH-1.

Test Plan:
1. Reset, then WIDTH=8, LSB_FIRST=0. Accept 0xA5 with shift_en tied high. serial_out over the next 8 cycles = 1,0,1,0,0,1,0,1. done pulses the cycle after bit 8. serial_out then = IDLE_LEVEL and busy = 0.
2. LSB_FIRST=1, accept 0xA5, shift_en high every 4th cycle. Bits = 1,0,1,0,0,1,0,1 (LSB first). Each bit is held 4 cycles. Exactly 8 strobes to done.
3. Back-to-back: accept 0x0F, then hold load_valid with 0xF0 ready. load_ready asserts only on the 8th strobe. Stream = 00001111 11110000 with no gap cycle. Two done pulses, 8 strobes apart. busy never drops between words.
4. Backpressure: in SHIFT, assert load_valid with a changing parallel_in on non-final cycles. load_ready = 0 and the transmitted word is unchanged.
5. Mid-word reset: assert rst after 3 bits of 0xFF for one cycle. Next cycle: serial_out = IDLE_LEVEL, busy = 0, no done pulse. A fresh accept of 0x81 then transmits correctly.
6. Idle behaviour: shift_en toggling with no load_valid. serial_valid stays 0, serial_out stays IDLE_LEVEL (also check with IDLE_LEVEL = 1), done never fires.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: parameterised parallel-in/serial-out serializer with valid/ready load and gapless back-to-back words
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int LSB_FIRST = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic             w_last;
  logic             w_accept;
  logic             w_bit;
  // final strobe of a word opens the load window so the next word follows with no gap
  always_comb begin
    w_last     = r_state == SHIFT && shift_en && r_cnt == CW'(WIDTH - 1);
    load_ready = !rst && (r_state == IDLE || w_last);
    w_accept   = load_valid && load_ready;
    w_bit      = LSB_FIRST != 0 ? r_shift[0] : r_shift[WIDTH-1];
  end
  assign busy         = r_state == SHIFT;
  assign serial_valid = busy;
  assign serial_out   = busy ? w_bit : IDLE_LEVEL;
  assign done         = r_done;
  // load, shift toward the output end with zero fill, and pulse done once the last bit retires
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_state <= SHIFT;
        r_shift <= parallel_in;
        r_cnt   <= '0;
      end else if (w_last) begin
        r_state <= IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (r_state == SHIFT && shift_en) begin
        r_shift <= LSB_FIRST != 0 ? r_shift >> 1 : r_shift << 1;
        r_cnt   <= r_cnt + CW'(1);
      end
    end
  end
endmodule
